// File: rtl/ppla_result_capture.sv
// rtl/ppla_result_capture.sv - SPI result capture buffer with timestamp deltas, min/max, count and overflow
// Each entry holds {ts_delta, data}; the host window reads one 32-bit half per address.
module ppla_result_capture #(
  parameter int DEPTH_LOG2 = 10,
  parameter int TS_WIDTH   = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ADDR_RESET,
  input  logic [31:0]           DIN,
  input  logic                  DIN_WE,
  input  logic [31:0]           READ_ADDR,
  output logic [31:0]           READ_DOUT,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  FULL,
  output logic                  OVERFLOW,
  output logic [31:0]           MIN_VAL,
  output logic [31:0]           MAX_VAL
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [TS_WIDTH-1:0] TS_MAX = '1;

  logic [63:0]           mem [0:DEPTH-1];
  logic [63:0]           ram_q;
  logic                  rd_ok;
  logic                  rd_hi;
  logic [TS_WIDTH-1:0]   ts_cnt;

  logic                  accept;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [TS_WIDTH-1:0]   wr_ts;
  logic [DEPTH_LOG2:0]   cnt_next;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_in_range;
  logic                  rd_in_count;

  // A clear in the same cycle as a write empties the buffer first, so the write lands in entry 0.
  always_comb begin
    accept      = DIN_WE && (ADDR_RESET || !FULL);
    wr_ptr      = ADDR_RESET ? '0 : COUNT[DEPTH_LOG2-1:0];
    wr_ts       = ADDR_RESET ? '0 : ts_cnt;
    cnt_next    = (ADDR_RESET ? '0 : COUNT) + {{DEPTH_LOG2{1'b0}}, accept};
    rd_idx      = READ_ADDR[DEPTH_LOG2:1];
    rd_in_range = (READ_ADDR >> (DEPTH_LOG2 + 1)) == 32'd0;
    rd_in_count = {1'b0, rd_idx} < COUNT;
  end

  // Plain single-port-write / registered-read array so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (accept && RESET) mem[wr_ptr] <= {32'(wr_ts), DIN};
    ram_q <= mem[rd_idx];
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      COUNT    <= '0;
      FULL     <= 1'b0;
      OVERFLOW <= 1'b0;
      ts_cnt   <= '0;
      MIN_VAL  <= 32'hFFFF_FFFF;
      MAX_VAL  <= 32'd0;
      rd_ok    <= 1'b0;
      rd_hi    <= 1'b0;
    end else begin
      rd_ok <= rd_in_range && rd_in_count;
      rd_hi <= READ_ADDR[0];
      COUNT <= cnt_next;
      FULL  <= cnt_next == DEPTH_CNT;

      if (ADDR_RESET) OVERFLOW <= 1'b0;
      else if (DIN_WE && FULL) OVERFLOW <= 1'b1;

      if (accept) begin
        MIN_VAL <= (ADDR_RESET || DIN < MIN_VAL) ? DIN : MIN_VAL;
        MAX_VAL <= (ADDR_RESET || DIN > MAX_VAL) ? DIN : MAX_VAL;
      end else if (ADDR_RESET) begin
        MIN_VAL <= 32'hFFFF_FFFF;
        MAX_VAL <= 32'd0;
      end

      if (accept) ts_cnt <= TS_WIDTH'(1);
      else if (ADDR_RESET) ts_cnt <= '0;
      else if (ts_cnt != TS_MAX) ts_cnt <= ts_cnt + TS_WIDTH'(1);
    end
  end

  // Mask applied after the RAM output register; the flags were sampled with the address.
  assign READ_DOUT = rd_ok ? (rd_hi ? ram_q[63:32] : ram_q[31:0]) : 32'd0;

endmodule
